endecoder_sched: RTL
====================

Name: endecoder_sched

Overview:
- Sequencer and arbiter for the shared encoder/decoder core inside the tt_um_endecoder top.
- Two requesters share the one codec core: an encode channel and a decode channel, each with a valid/ready handshake.
- The block grants the core round-robin, launches one operation, waits for completion, then returns the result on a single response channel.
- Sits between the ui_in/uio input-capture logic and the codec core; the response drives the uo_out path.

Parameters:
- DW, 8, data width of requests, core operand/result and response.
- TIMEOUT_CYC, 16, WAIT-state cycle limit; used only when SCHED_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enc_req_valid  in  1  encode request present.
- enc_req_ready  out  1  encode request accepted this cycle.
- enc_req_data  in  DW  encode operand.
- dec_req_valid  in  1  decode request present.
- dec_req_ready  out  1  decode request accepted this cycle.
- dec_req_data  in  DW  decode operand.
- core_start  out  1  one-cycle launch pulse to the core.
- core_op  out  1  0 = encode, 1 = decode; held stable from ISSUE through WAIT.
- core_din  out  DW  operand to the core; held stable from ISSUE through WAIT.
- core_done  in  1  one-cycle completion pulse from the core.
- core_dout  in  DW  core result; valid only when core_done=1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  result.
- rsp_is_dec  out  1  response belongs to the decode channel.
- rsp_err  out  1  response is a timeout error; tied 0 when SCHED_TIMEOUT_EN is undefined.
- busy  out  1  FSM state is not IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. State, op/operand registers and response registers are flops. The ready, start and valid strobes decode from state.
- IDLE:
  - If only one channel is valid, it is granted.
  - If both are valid, the channel not served last wins (last_grant register).
  - The granted channel's req_ready is 1 combinationally in IDLE; the other ready is 0. Both readies are 0 in every other state.
  - On handshake: latch operand into core_din, set core_op = channel, then go to ISSUE.
  - Ready never depends on the valid of the same channel; ready is computed from state and the arbitration result only.
- ISSUE: core_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On core_done=1: capture core_dout into rsp_data, set rsp_is_dec = core_op, set rsp_err=0, go to RESP.
  - core_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - rsp_valid=1; rsp_data, rsp_is_dec and rsp_err stay stable until rsp_ready=1.
  - On handshake: last_grant <= core_op, go to IDLE.
  - If rsp_ready is already high on entry, rsp_valid lasts 1 cycle.
- Latency:
  - Request handshake cycle N, core_start at N+1.
  - With core_done at cycle M (M >= N+2), rsp_valid rises at M+1.
  - Minimum 4 cycles between successive request acceptances.
- Reset:
  - All outputs 0: readies, core_start, core_op, core_din, rsp_valid, rsp_data, rsp_is_dec, rsp_err, busy.
  - State = IDLE; last_grant = 1 (decode), so encode wins the first tie.
- Reset mid-operation: the transaction is aborted. No response is produced, and a late core_done is ignored. The requester must re-issue.
- Valid dropped before grant: no handshake occurs and no state change.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on ISSUE and increments every WAIT cycle.
  - If the counter reaches TIMEOUT_CYC with no core_done: go to RESP with rsp_data=0, rsp_err=1, rsp_is_dec=core_op.
  - core_done arriving in the same cycle as the timeout wins: normal response, rsp_err=0.
- Undefined: no counter; WAIT lasts until core_done indefinitely; rsp_err is constant 0.

Test Plan:
- Single encode: reset, enc_req_valid=1, data=0x5A; core returns done 3 cycles after start with dout=0xA5 -> exactly one core_start with op=0 and din=0x5A; rsp_valid with rsp_data=0xA5, rsp_is_dec=0.
- Tie arbitration: enc and dec both valid continuously (data 0x11/0x22), rsp_ready=1 -> grant order enc, dec, enc, dec; core_op sequence 0,1,0,1; no request accepted twice.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stable, both req_ready=0, busy=1; the next request is accepted only after the rsp handshake.
- Spurious done: core_done pulses in IDLE and ISSUE -> ignored; the response uses the done seen in WAIT only.
- Reset mid-WAIT: assert rst one cycle during WAIT, then core_done -> no rsp_valid; all outputs 0; the next enc request is served normally.
- Timeout (SCHED_TIMEOUT_EN, TIMEOUT_CYC=16): core never asserts done -> rsp_valid 17 cycles after core_start with rsp_err=1, rsp_data=0x00. Without the macro, rsp_valid never rises and busy stays 1.

Source files
------------

// File: rtl/endecoder_sched.sv
// rtl/endecoder_sched.sv - round-robin sequencer/arbiter for the shared encode/decode core
// Defining SCHED_TIMEOUT_EN adds a WAIT-state timeout of TIMEOUT_CYC cycles.
module endecoder_sched #(
   parameter int DW          = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enc_req_valid,
   output logic          enc_req_ready,
   input  logic [DW-1:0] enc_req_data,
   input  logic          dec_req_valid,
   output logic          dec_req_ready,
   input  logic [DW-1:0] dec_req_data,
   output logic          core_start,
   output logic          core_op,
   output logic [DW-1:0] core_din,
   input  logic          core_done,
   input  logic [DW-1:0] core_dout,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_is_dec,
   output logic          rsp_err,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_last_grant;
   logic          r_core_op;
   logic [DW-1:0] r_core_din;
   logic [DW-1:0] r_rsp_data;
   logic          r_rsp_is_dec;
   logic          r_rsp_err;

   logic w_idle;
   logic w_enc_win;
   logic w_dec_win;
   logic w_enc_hs;
   logic w_dec_hs;
   logic w_req_hs;
   logic w_done;
   logic w_timeout;

   // A channel wins unless the other is also requesting and was not served last;
   // each ready looks only at the other channel's valid.
   assign w_idle        = (r_state == S_IDLE) && !rst;
   assign w_enc_win     = r_last_grant || !dec_req_valid;
   assign w_dec_win     = !r_last_grant || !enc_req_valid;
   assign enc_req_ready = w_idle && w_enc_win;
   assign dec_req_ready = w_idle && w_dec_win;
   assign w_enc_hs      = enc_req_valid && enc_req_ready;
   assign w_dec_hs      = dec_req_valid && dec_req_ready;
   assign w_req_hs      = w_enc_hs || w_dec_hs;
   assign w_done        = (r_state == S_WAIT) && core_done;

`ifdef SCHED_TIMEOUT_EN
   logic [7:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Fires on the WAIT cycle whose increment reaches TIMEOUT_CYC; a done in that cycle wins.
   assign w_timeout = (r_state == S_WAIT) && !core_done &&
                      (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
   // TIMEOUT_CYC is never 0, so this folds to a constant 0.
   assign w_timeout = (r_state == S_WAIT) && (TIMEOUT_CYC == 0);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req_hs) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_done || w_timeout) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_core_op    <= 1'b0;
         r_core_din   <= '0;
         r_rsp_data   <= '0;
         r_rsp_is_dec <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_req_hs) begin
            r_core_op  <= w_dec_hs;
            r_core_din <= w_dec_hs ? dec_req_data : enc_req_data;
         end
         if (w_done) begin
            r_rsp_data   <= core_dout;
            r_rsp_is_dec <= r_core_op;
            r_rsp_err    <= 1'b0;
         end else if (w_timeout) begin
            r_rsp_data   <= '0;
            r_rsp_is_dec <= r_core_op;
            r_rsp_err    <= 1'b1;
         end
         if ((r_state == S_RESP) && rsp_ready) begin
            r_last_grant <= r_core_op;
         end
      end
   end

   assign core_start = (r_state == S_ISSUE);
   assign core_op    = r_core_op;
   assign core_din   = r_core_din;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_data   = r_rsp_data;
   assign rsp_is_dec = r_rsp_is_dec;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != S_IDLE);

endmodule
